alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port flush, input, 1, synchronous clear of all in-flight operations.
REQ-004 SHALL have port in_valid, input, 1, issue request valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts the request this cycle.
REQ-006 SHALL have port in_class, input, 2, 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 SHALL have ports in_funct3, input, 3, and in_funct7_5, input, 1, instruction function fields.
REQ-008 SHALL have ports in_rs1, in_rs2 and in_imm, input, 64 each, operands and sign-extended immediate.
REQ-009 SHALL have ports alu_a and alu_b, output, 64 each, and alu_op, output, 4, which drive the ALU ({ainvert, bnegate, op[1:0]}).
REQ-010 SHALL have ports alu_result, input, 64, alu_zero, input, 1, and alu_overflow, input, 1, the combinational ALU response for the same cycle.
REQ-011 SHALL have ports out_valid, output, 1, and out_ready, input, 1, result handshake.
REQ-012 SHALL have ports out_result, output, 64, out_taken, output, 1, out_overflow, output, 1, and out_illegal, output, 1, the registered response.

Function
REQ-013 SHALL encode ALU ops as AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
REQ-014 SHALL decode class 00 as ADD, with b=imm.
REQ-015 SHALL decode class 10 (b=rs2) as: f3 000 with f7_5=0 -> ADD; f3 000 with f7_5=1 -> SUB; f3 111 -> AND; f3 110 -> OR; f3 010 -> SLT.
REQ-016 SHALL decode class 11 (b=imm; f7_5 ignored) using the same f3 map, with f3 000 always ADD.
REQ-017 SHALL decode class 01 (b=rs2) as: f3 000 BEQ and f3 001 BNE -> SUB; f3 100 BLT and f3 101 BGE -> SLT.
REQ-018 SHALL treat any other f3 as illegal: alu_op=ADD, out_result=0, out_taken=0, out_illegal=1.
REQ-019 SHALL drive alu_a=rs1 for every class.
REQ-020 SHALL compute out_taken as: BEQ alu_zero; BNE !alu_zero; BLT alu_result[0]; BGE !alu_result[0]; 0 for all non-branch classes.
REQ-021 SHALL use a two-stage pipeline: S1 holds decoded a/b/op/kind and drives the alu_* outputs from registers; S2 captures the ALU response and the taken/illegal flags.
REQ-022 SHALL define a request as accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-023 SHALL assert out_valid exactly 2 cycles after acceptance when there is no backpressure.
REQ-024 SHALL sustain a throughput of 1 request per cycle.
REQ-025 SHALL compute in_ready = !s1_valid | s2_free, where s2_free = !out_valid | out_ready (combinational, no bubble).
REQ-026 SHALL advance S1 to S2 only when s2_free.
REQ-027 SHALL hold S2 contents stable while out_valid=1 and out_ready=0.
REQ-028 SHALL allow accept into S1 and transfer from S1 to S2 in the same cycle.
REQ-029 SHALL, when S2 drains with S1 empty, load S2 with nothing and drop out_valid next cycle.
REQ-030 SHALL, on flush=1, clear s1_valid and out_valid next cycle and ignore any same-cycle request.
REQ-031 SHALL hold in_ready=0 during a flush cycle.
REQ-032 SHALL give reset precedence over flush, and flush precedence over the handshake.
REQ-033 SHALL pass out_overflow from alu_overflow unchanged for every class; it is informational only.

Reset
REQ-034 SHALL, on reset, drive s1_valid=0, out_valid=0, alu_a=0, alu_b=0, alu_op=0010, out_result=0, out_taken=0, out_overflow=0, out_illegal=0.
REQ-035 SHALL drive in_ready=0 during reset and 1 in the first cycle after reset.
REQ-036 SHALL discard in-flight operations when reset is asserted mid-operation; no partial result is output.

Structure
REQ-037 SHALL place the ALU op codes, class codes and funct3 codes in a shared package/header (alu_defs) reused by the ALU and control logic.
REQ-038 SHALL implement decode as one combinational sub-module alu_op_decode (class, f3, f7_5 -> op, use_imm, branch kind, illegal).

Verification
REQ-039 SHALL cover: R-type SUB with rs1=5, rs2=7 -> out_result=0xFFFF_FFFF_FFFF_FFFE, out_valid 2 cycles after accept.
REQ-040 SHALL cover: BLT with rs1=-3, rs2=2 -> alu_op=0111, out_taken=1; BGE with the same operands -> out_taken=0.
REQ-041 SHALL cover: BEQ with rs1=rs2=0x1234 -> out_taken=1; BNE with the same operands -> 0.
REQ-042 SHALL cover: back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0 after S1 fills, S2 held stable, no loss or duplication once ready.
REQ-043 SHALL cover: class 10 with f3=001 -> out_illegal=1, out_result=0.
REQ-044 SHALL cover: flush with both stages full, then reset mid-stream -> out_valid=0 next cycle and every output at its REQ-034 value.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: op codes driven onto the ALU, instruction class codes,
// funct3 codes and the branch-kind tag carried down the issue pipeline.
package alu_defs;

    localparam int XLEN = 64;

    // ALU control word {ainvert, bnegate, op[1:0]}
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    // Instruction class as presented on the issue port
    localparam logic [1:0] CLS_LDST   = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_RTYPE  = 2'b10;
    localparam logic [1:0] CLS_ITYPE  = 2'b11;

    // funct3 codes for arithmetic classes (R-type and I-type)
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 codes for branches
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Which condition S2 evaluates when the ALU response comes back
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4
    } br_kind_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decoder: turns class/funct3/funct7[5] into the ALU
// op, the B-operand source, the branch kind and an illegal flag.
module alu_op_decode
    import alu_defs::*;
(
    input  logic [1:0] i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_op_e    o_op,
    output logic       o_use_imm,
    output br_kind_e   o_br_kind,
    output logic       o_illegal
);

    // Decode table; unknown funct3 values fall back to ADD with the illegal flag set
    always_comb begin
        o_op      = ALU_ADD;
        o_use_imm = 1'b0;
        o_br_kind = BR_NONE;
        o_illegal = 1'b0;
        case (i_class)
            CLS_LDST: begin
                o_use_imm = 1'b1;
            end
            CLS_BRANCH: begin
                case (i_funct3)
                    F3_BEQ: begin
                        o_op      = ALU_SUB;
                        o_br_kind = BR_EQ;
                    end
                    F3_BNE: begin
                        o_op      = ALU_SUB;
                        o_br_kind = BR_NE;
                    end
                    F3_BLT: begin
                        o_op      = ALU_SLT;
                        o_br_kind = BR_LT;
                    end
                    F3_BGE: begin
                        o_op      = ALU_SLT;
                        o_br_kind = BR_GE;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            CLS_RTYPE, CLS_ITYPE: begin
                o_use_imm = (i_class == CLS_ITYPE);
                case (i_funct3)
                    F3_ADD_SUB: o_op = ((i_class == CLS_RTYPE) && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_AND:     o_op = ALU_AND;
                    F3_OR:      o_op = ALU_OR;
                    F3_SLT:     o_op = ALU_SLT;
                    default:    o_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage ALU issue controller. S1 registers the decoded operands and op and
// drives the external combinational ALU; S2 captures the ALU response together
// with the branch outcome and holds it until the consumer takes it.
module alu_issue_ctrl
    import alu_defs::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_class,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            out_overflow,
    output logic            out_illegal
);

    alu_op_e         w_dec_op;
    logic            w_dec_use_imm;
    br_kind_e        w_dec_kind;
    logic            w_dec_illegal;

    logic            w_s2_free;
    logic            w_accept;
    logic            w_taken;

    logic            r_s1_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    alu_op_e         r_alu_op;
    br_kind_e        r_s1_kind;
    logic            r_s1_illegal;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic            r_out_taken;
    logic            r_out_overflow;
    logic            r_out_illegal;

    alu_op_decode u_decode (
        .i_class    (in_class),
        .i_funct3   (in_funct3),
        .i_funct7_5 (in_funct7_5),
        .o_op       (w_dec_op),
        .o_use_imm  (w_dec_use_imm),
        .o_br_kind  (w_dec_kind),
        .o_illegal  (w_dec_illegal)
    );

    // S2 can take new data when it is empty or being drained this cycle;
    // in_ready is held low while reset or flush is active so nothing sneaks in
    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !reset && !flush && (!r_s1_valid || w_s2_free);
    assign w_accept  = in_valid && in_ready;

    // Resolve the branch condition from the ALU response of the op sitting in S1
    always_comb begin
        w_taken = 1'b0;
        case (r_s1_kind)
            BR_EQ:   w_taken = alu_zero;
            BR_NE:   w_taken = !alu_zero;
            BR_LT:   w_taken = alu_result[0];
            BR_GE:   w_taken = !alu_result[0];
            default: w_taken = 1'b0;
        endcase
    end

    // S1: capture a newly accepted request, or empty out once it moves to S2
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= ALU_ADD;
            r_s1_kind    <= BR_NONE;
            r_s1_illegal <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_alu_a      <= in_rs1;
            r_alu_b      <= w_dec_use_imm ? in_imm : in_rs2;
            r_alu_op     <= w_dec_op;
            r_s1_kind    <= w_dec_kind;
            r_s1_illegal <= w_dec_illegal;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: latch the ALU response when S1 advances; contents are frozen under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_taken    <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_illegal  <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result   <= r_s1_illegal ? '0 : alu_result;
                r_out_taken    <= w_taken;
                r_out_overflow <= alu_overflow;
                r_out_illegal  <= r_s1_illegal;
            end
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_taken    = r_out_taken;
    assign out_overflow = r_out_overflow;
    assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed requests push hand-computed
// responses into a queue, a monitor pops and compares on every output handshake.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [63:0] result;
        logic        taken;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [1:0]  inClass;
    logic [2:0]  inFunct3;
    logic        inFunct75;
    logic [63:0] inRs1;
    logic [63:0] inRs2;
    logic [63:0] inImm;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [3:0]  aluOp;
    logic [63:0] aluResult;
    logic        aluZero;
    logic        aluOverflow;
    logic        outValid;
    logic        outReady;
    logic [63:0] outResult;
    logic        outTaken;
    logic        outOverflow;
    logic        outIllegal;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .in_class     (inClass),
        .in_funct3    (inFunct3),
        .in_funct7_5  (inFunct75),
        .in_rs1       (inRs1),
        .in_rs2       (inRs2),
        .in_imm       (inImm),
        .alu_a        (aluA),
        .alu_b        (aluB),
        .alu_op       (aluOp),
        .alu_result   (aluResult),
        .alu_zero     (aluZero),
        .alu_overflow (aluOverflow),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_result   (outResult),
        .out_taken    (outTaken),
        .out_overflow (outOverflow),
        .out_illegal  (outIllegal)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU answering whatever S1 drives
    always_comb begin
        aluResult   = 64'd0;
        aluOverflow = 1'b0;
        case (aluOp)
            4'b0000: aluResult = aluA & aluB;
            4'b0001: aluResult = aluA | aluB;
            4'b0010: begin
                aluResult   = aluA + aluB;
                aluOverflow = (aluA[63] == aluB[63]) && (aluResult[63] != aluA[63]);
            end
            4'b0110: begin
                aluResult   = aluA - aluB;
                aluOverflow = (aluA[63] != aluB[63]) && (aluResult[63] != aluA[63]);
            end
            4'b0111: aluResult = ($signed(aluA) < $signed(aluB)) ? 64'd1 : 64'd0;
            default: aluResult = 64'd0;
        endcase
        aluZero = (aluResult == 64'd0);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_alu_a"}, aluA, 64'd0);
        checkOutput({tag, "_alu_b"}, aluB, 64'd0);
        checkOutput({tag, "_alu_op"}, 64'(aluOp), 64'h2);
        checkOutput({tag, "_out_result"}, outResult, 64'd0);
        checkOutput({tag, "_out_taken"}, 64'(outTaken), 64'd0);
        checkOutput({tag, "_out_overflow"}, 64'(outOverflow), 64'd0);
        checkOutput({tag, "_out_illegal"}, 64'(outIllegal), 64'd0);
    endtask

    // Present one request and hold it until accepted; returns just after the accepting edge
    task automatic applyStimulus(input logic [1:0] cls, input logic [2:0] f3, input logic f75,
                                 input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                                 input logic [63:0] expRes, input logic expTaken, input logic expOvf,
                                 input logic expIll);
        exp_t e;
        bit   accepted = 1'b0;
        inValid   = 1'b1;
        inClass   = cls;
        inFunct3  = f3;
        inFunct75 = f75;
        inRs1     = rs1;
        inRs2     = rs2;
        inImm     = imm;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (inReady) begin
                e.result = expRes;
                e.taken  = expTaken;
                e.ovf    = expOvf;
                e.ill    = expIll;
                expQ.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected accept within 50 cycles");
        end
    endtask

    // Let the pipeline empty with the consumer ready; returns just after a clock edge
    task automatic waitDrain(input string tag);
        bit drained = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !outValid) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_drained"}, 64'(drained), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && !flush && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got result 0x%0h expected no output", outResult);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sb_result", outResult, monExp.result);
                checkOutput("sb_taken", 64'(outTaken), 64'(monExp.taken));
                checkOutput("sb_overflow", 64'(outOverflow), 64'(monExp.ovf));
                checkOutput("sb_illegal", 64'(outIllegal), 64'(monExp.ill));
            end
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b1;
        inClass   = 2'b00;
        inFunct3  = 3'b000;
        inFunct75 = 1'b0;
        inRs1     = 64'd0;
        inRs2     = 64'd0;
        inImm     = 64'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkResetValues("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(inReady), 64'd1);
        @(posedge clk);
        #1;

        // R-type SUB 5-7 with the two-cycle latency observed directly
        applyStimulus(2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sub_lat1_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("sub_lat2_valid", 64'(outValid), 64'd1);
        @(posedge clk);
        #1;
        waitDrain("sub");

        // Branches, illegal op and the arithmetic map, issued back to back
        applyStimulus(2'b01, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd0, 64'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("blt_alu_op", 64'(aluOp), 64'h7);
        checkOutput("blt_alu_b", aluB, 64'd2);
        applyStimulus(2'b01, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd0, 64'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 3'b001, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b001, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ill_alu_op", 64'(aluOp), 64'h2);
        applyStimulus(2'b00, 3'b011, 1'b0, 64'd100, 64'd999, 64'hFFFF_FFFF_FFFF_FFFC, 64'd96, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_alu_b", aluB, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(2'b11, 3'b111, 1'b1, 64'hF0F0, 64'd0, 64'hFF, 64'hF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b11, 3'b000, 1'b1, 64'd10, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b110, 1'b0, 64'hF00, 64'h0F, 64'd0, 64'hF0F, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b10, 3'b010, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        waitDrain("stream");

        // Backpressure: fill both stages, hold out_ready low for three cycles
        outReady = 1'b0;
        applyStimulus(2'b10, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 64'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b000, 1'b1, 64'd10, 64'd4, 64'd0, 64'd6, 1'b0, 1'b0, 1'b0);
        inValid  = 1'b1;
        inClass  = 2'b10;
        inFunct3 = 3'b111;
        inRs1    = 64'hFF;
        inRs2    = 64'h0F;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(inReady), 64'd0);
            checkOutput("bp_out_valid", 64'(outValid), 64'd1);
            checkOutput("bp_held_result", outResult, 64'd3);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        applyStimulus(2'b10, 3'b111, 1'b0, 64'hFF, 64'h0F, 64'd0, 64'h0F, 1'b0, 1'b0, 1'b0);
        waitDrain("bp");

        // Flush with both stages full and a competing request on the input
        outReady = 1'b0;
        applyStimulus(2'b10, 3'b000, 1'b0, 64'd20, 64'd1, 64'd0, 64'd21, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b000, 1'b0, 64'd30, 64'd1, 64'd0, 64'd31, 1'b0, 1'b0, 1'b0);
        flush    = 1'b1;
        inValid  = 1'b1;
        inClass  = 2'b10;
        inFunct3 = 3'b000;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(inReady), 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        inValid = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("flush_s1_cleared", 64'(outValid), 64'd0);
        @(posedge clk);
        #1;
        outReady = 1'b1;

        // Reset while the pipeline holds two operations
        outReady = 1'b0;
        applyStimulus(2'b10, 3'b000, 1'b0, 64'd40, 64'd2, 64'd0, 64'd42, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b11, 3'b110, 1'b0, 64'hABCD, 64'd0, 64'h10, 64'hABDD, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", 64'(inReady), 64'd0);
        @(posedge clk);
        #1;
        expQ.delete();
        @(negedge clk);
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        reset    = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release_in_ready", 64'(inReady), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 3'b010, 1'b0, 64'd1, 64'd0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
        waitDrain("final");
        checkOutput("sb_empty", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
